// File: rtl/mem_bank_pipe.sv
// Single-port scratch bank with per-byte writes, a post-reset clear sequence,
// a 1- or 2-cycle read pipeline and an in-order, backpressured response FIFO.
module mem_bank_pipe #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 48,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter int NBYTES     = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [NBYTES-1:0]     be,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rerr,
    output logic                  init_done
);
    // state | meaning
    // INIT  | clearing one word per cycle, requests blocked
    // RUN   | serving requests until the next reset
    typedef enum logic {INIT, RUN} state_t;

    localparam int FIFO_DEPTH = RD_LAT + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } rsp_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [CNT_W-1:0]      outst;
    logic [CNT_W-1:0]      fifo_cnt, fifo_cnt_n;
    rsp_t                  fifo_q [FIFO_DEPTH];
    rsp_t                  fifo_n [FIFO_DEPTH];
    rsp_t                  rd_cap, push_rsp;
    logic                  in_range, wr_acc, rd_acc, push, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == INIT)
                init_cnt <= init_cnt + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_n   = state;
        ready     = 1'b0;
        init_done = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == ADDR_WIDTH'(DEPTH - 1))
                    state_n = RUN;
            end
            RUN: begin
                init_done = 1'b1;
                ready     = (outst < CNT_W'(FIFO_DEPTH));
            end
        endcase
    end

    assign in_range = (int'(addr) < DEPTH);
    assign wr_acc   = valid && ready && wr_rd;
    assign rd_acc   = valid && ready && !wr_rd;

    // Array has no reset; INIT rewrites every word after each reset.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < NBYTES; i++)
                if (be[i])
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rd_cap.data = in_range ? mem[addr] : '0;
    assign rd_cap.err  = !in_range;

    generate
        if (RD_LAT == 2) begin : g_pipe
            rsp_t pipe_q;
            logic pipe_v;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_v <= 1'b0;
                    pipe_q <= '0;
                end else begin
                    pipe_v <= rd_acc;
                    if (rd_acc)
                        pipe_q <= rd_cap;
                end
            end
            assign push     = pipe_v;
            assign push_rsp = pipe_q;
        end else begin : g_nopipe
            assign push     = rd_acc;
            assign push_rsp = rd_cap;
        end
    endgenerate

    assign rvalid = (fifo_cnt != '0);
    assign pop    = rvalid && rready;

    // Shift FIFO: entry 0 is the registered head and keeps its value once drained.
    always_comb begin
        fifo_n     = fifo_q;
        fifo_cnt_n = fifo_cnt;
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++)
                if (i + 1 < int'(fifo_cnt))
                    fifo_n[i] = fifo_q[i + 1];
            fifo_cnt_n = fifo_cnt - CNT_W'(1);
        end
        if (push) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (i == int'(fifo_cnt_n))
                    fifo_n[i] = push_rsp;
            fifo_cnt_n = fifo_cnt_n + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= '0;
            outst    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_q[i] <= '0;
        end else begin
            fifo_cnt <= fifo_cnt_n;
            fifo_q   <= fifo_n;
            if (rd_acc && !pop)
                outst <= outst + CNT_W'(1);
            else if (pop && !rd_acc)
                outst <= outst - CNT_W'(1);
        end
    end

    assign rdata = fifo_q[0].data;
    assign rerr  = fifo_q[0].err;

endmodule

// File: tb/tb_mem_bank_pipe.sv
// Bench for mem_bank_pipe: an RD_LAT=1 and an RD_LAT=2 instance, each checked
// every cycle against a queue-based reference model plus directed scenarios.
module tb_mem_bank_pipe;
    localparam int DEPTH = 48;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          avail;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid [2];
    logic        wr_rd [2];
    logic [5:0]  addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic        rready [2];
    logic        ready [2];
    logic        rvalid [2];
    logic [31:0] rdata [2];
    logic        rerr [2];
    logic        init_done [2];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          since_rel [2];
    logic [31:0] mdl [2][DEPTH];
    rsp_t        expq [2][$];
    logic [31:0] last_data [2];
    logic        last_err [2];
    bit          acc [2];

    always #5 clk = ~clk;

    mem_bank_pipe #(.WIDTH(32), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .valid(valid[0]), .ready(ready[0]), .wr_rd(wr_rd[0]),
        .addr(addr[0]), .wdata(wdata[0]), .be(be[0]), .rvalid(rvalid[0]),
        .rready(rready[0]), .rdata(rdata[0]), .rerr(rerr[0]), .init_done(init_done[0])
    );

    mem_bank_pipe #(.WIDTH(32), .DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .valid(valid[1]), .ready(ready[1]), .wr_rd(wr_rd[1]),
        .addr(addr[1]), .wdata(wdata[1]), .be(be[1]), .rvalid(rvalid[1]),
        .rready(rready[1]), .rdata(rdata[1]), .rerr(rerr[1]), .init_done(init_done[1])
    );

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // Reference model: instance d has latency d+1. Evaluated mid-cycle; the
    // accept/pop decisions made here take effect at the following rising edge.
    always @(negedge clk) begin : model
        int   a;
        bit   run, exp_ready, exp_rv;
        rsp_t r;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("rst_ready", d, ready[d], 1'b0);
                chk("rst_rvalid", d, rvalid[d], 1'b0);
                chk("rst_rdata", d, rdata[d], 32'h0);
                chk("rst_rerr", d, rerr[d], 1'b0);
                chk("rst_init_done", d, init_done[d], 1'b0);
                expq[d].delete();
                since_rel[d] = 0;
                last_data[d] = '0;
                last_err[d]  = 1'b0;
                for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
            end else begin
                run       = (since_rel[d] >= DEPTH);
                exp_ready = run && (expq[d].size() < d + 2);
                exp_rv    = 1'b0;
                if (expq[d].size() > 0)
                    exp_rv = (expq[d][0].avail <= cyc);
                chk("init_done", d, init_done[d], run);
                chk("ready", d, ready[d], exp_ready);
                chk("rvalid", d, rvalid[d], exp_rv);
                if (exp_rv) begin
                    chk("rdata", d, rdata[d], expq[d][0].data);
                    chk("rerr", d, rerr[d], expq[d][0].err);
                end else begin
                    chk("rdata_hold", d, rdata[d], last_data[d]);
                end
                if (exp_rv && rready[d]) begin
                    last_data[d] = expq[d][0].data;
                    last_err[d]  = expq[d][0].err;
                    void'(expq[d].pop_front());
                end
                if (valid[d] && exp_ready) begin
                    a = int'(addr[d]);
                    if (wr_rd[d]) begin
                        if (a < DEPTH)
                            for (int b = 0; b < 4; b++)
                                if (be[d][b]) mdl[d][a][8*b +: 8] = wdata[d][8*b +: 8];
                    end else begin
                        r.data  = (a < DEPTH) ? mdl[d][a] : 32'h0;
                        r.err   = (a >= DEPTH);
                        r.avail = cyc + d + 1;
                        expq[d].push_back(r);
                    end
                end
                since_rel[d]++;
            end
        end
        cyc++;
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic req(input int d, input bit wr, input logic [5:0] a, input logic [31:0] wd, input logic [3:0] b);
        int n = 0;
        valid[d] = 1'b1; wr_rd[d] = wr; addr[d] = a; wdata[d] = wd; be[d] = b;
        @(negedge clk);
        while (!ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready[d]) begin
            checks++;
            errors++;
            $error("FAIL req_timeout dut%0d observed ready 0 expected 1", d);
        end
        @(posedge clk); #1;
        valid[d] = 1'b0;
    endtask

    task automatic rd_check(input int d, input logic [5:0] a, input logic [31:0] exp_d, input logic exp_e);
        int n = 1;
        rready[d] = 1'b1;
        req(d, 1'b0, a, 32'h0, 4'h0);
        while (!rvalid[d] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_latency", d, n, d + 1);
        chk("rd_data", d, rdata[d], exp_d);
        chk("rd_err", d, rerr[d], exp_e);
        @(posedge clk); #1;
    endtask

    task automatic wait_init();
        int c = 0;
        while (!init_done[0] && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk("init_cycles", 0, c, DEPTH);
        chk("init_done_both", 1, init_done[1], 1'b1);
    endtask

    task automatic backpressure(input int d);
        rready[d] = 1'b0;
        for (int k = 0; k <= d + 1; k++) req(d, 1'b0, 6'(k), 32'h0, 4'h0);
        valid[d] = 1'b1; wr_rd[d] = 1'b0; addr[d] = 6'(d + 2);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", d, ready[d], 1'b0);
        end
        @(posedge clk); #1;
        rready[d] = 1'b1;
        req(d, 1'b0, 6'(d + 2), 32'h0, 4'h0);
        req(d, 1'b0, 6'(d + 3), 32'h0, 4'h0);
        repeat (8) @(posedge clk);
        #1;
        chk("bp_drain", d, expq[d].size(), 0);
    endtask

    task automatic throughput(input int d);
        int nrv = 0;
        rready[d] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            valid[d] = 1'b1; wr_rd[d] = 1'b0; addr[d] = 6'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            chk("tp_ready", d, ready[d], 1'b1);
            if (rvalid[d]) nrv++;
            @(posedge clk); #1;
        end
        valid[d] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rvalid[d]) nrv++;
            @(posedge clk); #1;
        end
        chk("tp_rvalid_cycles", d, nrv, 16);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0; wr_rd[d] = 1'b0; addr[d] = '0;
            wdata[d] = '0; be[d] = '0; rready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init();

        for (int d = 0; d < 2; d++) rd_check(d, 6'd47, 32'h0, 1'b0);

        for (int d = 0; d < 2; d++) begin
            req(d, 1'b1, 6'd5, 32'hAABBCCDD, 4'hF);
            req(d, 1'b1, 6'd5, 32'h11223344, 4'b0101);
            rd_check(d, 6'd5, 32'hAA22CC44, 1'b0);
            req(d, 1'b1, 6'd6, 32'h55667788, 4'h0);
            rd_check(d, 6'd6, 32'h0, 1'b0);
        end

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) req(d, 1'b1, 6'(k), $urandom, 4'hF);
            backpressure(d);
        end

        for (int d = 0; d < 2; d++) throughput(d);

        for (int d = 0; d < 2; d++) begin
            req(d, 1'b1, 6'd50, 32'hDEADBEEF, 4'hF);
            rd_check(d, 6'd50, 32'h0, 1'b1);
            rd_check(d, 6'd47, 32'h0, 1'b0);
        end

        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!valid[d] || acc[d]) begin
                    valid[d] = ($urandom_range(0, 3) != 0);
                    wr_rd[d] = 1'($urandom_range(0, 1));
                    addr[d]  = 6'($urandom_range(0, 55));
                    wdata[d] = $urandom;
                    be[d]    = 4'($urandom_range(0, 15));
                end
                rready[d] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) acc[d] = valid[d] && ready[d];
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            rready[d] = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk("rand_drain", d, expq[d].size(), 0);

        for (int d = 0; d < 2; d++) req(d, 1'b1, 6'd5, 32'hCAFEF00D, 4'hF);
        for (int d = 0; d < 2; d++) rready[d] = 1'b0;
        req(0, 1'b0, 6'd1, 32'h0, 4'h0);
        req(0, 1'b0, 6'd5, 32'h0, 4'h0);
        req(1, 1'b0, 6'd1, 32'h0, 4'h0);
        req(1, 1'b0, 6'd5, 32'h0, 4'h0);
        for (int d = 0; d < 2; d++) chk("pre_rst_rvalid", d, rvalid[d], 1'b1);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_async_rvalid", d, rvalid[d], 1'b0);
            chk("rst_async_ready", d, ready[d], 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) rready[d] = 1'b1;
        wait_init();
        for (int d = 0; d < 2; d++) rd_check(d, 6'd5, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
